// File: rtl/wb_sram_scheduler_pkg.sv
// Shared types and helpers for the Wishbone SRAM round-robin scheduler.
package wb_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOwn,
    StErr,
    StDrain
  } state_e;

  localparam int unsigned WDOG_W = 10;

  // Index of the set bit in a one-hot vector (highest set bit if several).
  function automatic int unsigned onehot_to_idx(input logic [31:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (onehot[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_sram_scheduler_if.sv
// Bus bundle between the requesters, the scheduler and the SRAM slave port.
// slave: scheduler view. master: environment view (requesters plus SRAM).
interface wb_sram_scheduler_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_cyc_i;
  logic [NUM_REQ-1:0]    req_stb_i;
  logic [NUM_REQ-1:0]    req_we_i;
  logic [4*NUM_REQ-1:0]  req_sel_i;
  logic [32*NUM_REQ-1:0] req_adr_i;
  logic [32*NUM_REQ-1:0] req_dat_i;
  logic [31:0]           req_dat_o;
  logic [NUM_REQ-1:0]    req_ack_o;
  logic [NUM_REQ-1:0]    req_err_o;
  logic                  sram_cyc_o;
  logic                  sram_stb_o;
  logic                  sram_we_o;
  logic [3:0]            sram_sel_o;
  logic [31:0]           sram_adr_o;
  logic [31:0]           sram_dat_o;
  logic                  sram_ack_i;
  logic [31:0]           sram_dat_i;
  logic [NUM_REQ-1:0]    grant_o;
  logic                  busy_o;

  modport slave (
    input  req_cyc_i, req_stb_i, req_we_i, req_sel_i, req_adr_i, req_dat_i,
    input  sram_ack_i, sram_dat_i,
    output req_dat_o, req_ack_o, req_err_o,
    output sram_cyc_o, sram_stb_o, sram_we_o, sram_sel_o, sram_adr_o, sram_dat_o,
    output grant_o, busy_o
  );

  modport master (
    output req_cyc_i, req_stb_i, req_we_i, req_sel_i, req_adr_i, req_dat_i,
    output sram_ack_i, sram_dat_i,
    input  req_dat_o, req_ack_o, req_err_o,
    input  sram_cyc_o, sram_stb_o, sram_we_o, sram_sel_o, sram_adr_o, sram_dat_o,
    input  grant_o, busy_o
  );
endinterface

// File: rtl/wb_sram_scheduler_rr_priority_picker.sv
// Combinational round-robin picker: first requester at or above last+1 (wrapping).
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdxW    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    last_i,
  output logic [NUM_REQ-1:0] winner_o,
  output logic               valid_o
);

  // Walk offsets from farthest to nearest so the nearest active requester wins last.
  always_comb begin
    int idx;
    winner_o = '0;
    idx      = 0;
    for (int off = int'(NUM_REQ); off >= 1; off--) begin
      idx = (int'(last_i) + off) % int'(NUM_REQ);
      if (req_i[idx]) begin
        winner_o      = '0;
        winner_o[idx] = 1'b1;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/wb_sram_scheduler.sv
// Round-robin owner of the shared SRAM Wishbone port with a per-cycle ack watchdog.
module wb_sram_scheduler
  import wb_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input logic                wb_clk_i,
  input logic                wb_rst_i,
  wb_sram_scheduler_if.slave bus
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic [NUM_REQ-1:0]  winner;
  logic                winner_vld;
  logic                own_cyc;
  logic                own_stb;

  rr_priority_picker #(
    .NUM_REQ(NUM_REQ),
    .IdxW   (IdxW)
  ) u_picker (
    .req_i   (bus.req_cyc_i),
    .last_i  (last_q),
    .winner_o(winner),
    .valid_o (winner_vld)
  );

  // last_q doubles as the owner index while a grant is held.
  assign own_cyc = bus.req_cyc_i[last_q];
  assign own_stb = bus.req_stb_i[last_q];

  // Next-state: arbitration, ownership tenure, watchdog and error/drain sequencing.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    unique case (state_q)
      StIdle: begin
        if (winner_vld) begin
          state_d = StOwn;
          grant_d = winner;
          last_d  = IdxW'(onehot_to_idx(32'(winner)));
          wdog_d  = '0;
        end
      end
      StOwn: begin
        if (!own_cyc) begin
          state_d = StIdle;
          grant_d = '0;
          wdog_d  = '0;
        end else if (own_stb && !bus.sram_ack_i) begin
          wdog_d = wdog_q + 1'b1;
          if (wdog_d >= WDOG_W'(TIMEOUT)) state_d = StErr;
        end else begin
          // An ack on the expiry cycle lands here and wins over the timeout.
          wdog_d = '0;
        end
      end
      StErr: begin
        wdog_d = '0;
        if (own_cyc) begin
          state_d = StDrain;
        end else begin
          state_d = StIdle;
          grant_d = '0;
        end
      end
      StDrain: begin
        if (!own_cyc) begin
          state_d = StIdle;
          grant_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // Outputs: owner passthrough only in OWN, error pulse only in ERR, zero otherwise.
  always_comb begin
    bus.sram_cyc_o = 1'b0;
    bus.sram_stb_o = 1'b0;
    bus.sram_we_o  = 1'b0;
    bus.sram_sel_o = '0;
    bus.sram_adr_o = '0;
    bus.sram_dat_o = '0;
    bus.req_ack_o  = '0;
    bus.req_err_o  = '0;
    bus.req_dat_o  = '0;
    if (state_q == StOwn) begin
      bus.sram_cyc_o        = own_cyc;
      bus.sram_stb_o        = own_stb;
      bus.sram_we_o         = bus.req_we_i[last_q];
      bus.sram_sel_o        = bus.req_sel_i[4*last_q +: 4];
      bus.sram_adr_o        = bus.req_adr_i[32*last_q +: 32];
      bus.sram_dat_o        = bus.req_dat_i[32*last_q +: 32];
      bus.req_ack_o[last_q] = bus.sram_ack_i;
      bus.req_dat_o         = bus.sram_dat_i;
    end
    if (state_q == StErr) bus.req_err_o[last_q] = 1'b1;
  end

  assign bus.grant_o = grant_q;
  assign bus.busy_o  = (state_q != StIdle);

  // State, grant, round-robin pointer and watchdog registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IdxW'(NUM_REQ - 1);
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: doc/wb_sram_scheduler.md
# wb_sram_scheduler

Round-robin scheduler that shares the single `SRAM_1024x32` Wishbone slave port between `NUM_REQ` Wishbone managers (management SoC path plus team projects). It sits between the requesters and the SRAM's `wbs_*` slave port. Each granted requester owns the SRAM for one complete Wishbone cycle, from `cyc` assertion to `cyc` deassertion. A per-cycle watchdog returns `err` to a requester whose access the SRAM never acknowledges.

## Interface
Clock is `wb_clk_i`; reset is `wb_rst_i`, synchronous and active-high. Everything is in the one clock domain.

Parameters
- `NUM_REQ`, default 4: number of requesters, minimum 2.
- `TIMEOUT`, default 255: number of cycles with `stb` high and no ack before the block aborts with an error, range 1..1023.

Ports
- `wb_clk_i`  in  1: clock.
- `wb_rst_i`  in  1: synchronous active-high reset.
- `req_cyc_i`  in  NUM_REQ: per-requester `cyc`.
- `req_stb_i`  in  NUM_REQ: per-requester `stb`.
- `req_we_i`  in  NUM_REQ: per-requester write enable.
- `req_sel_i`  in  4*NUM_REQ: byte selects, flattened; requester k uses `[4k+:4]`.
- `req_adr_i`  in  32*NUM_REQ: addresses, flattened; requester k uses `[32k+:32]`.
- `req_dat_i`  in  32*NUM_REQ: write data, flattened; requester k uses `[32k+:32]`.
- `req_dat_o`  out  32: read data, shared by all requesters; valid only with that requester's ack.
- `req_ack_o`  out  NUM_REQ: per-requester ack.
- `req_err_o`  out  NUM_REQ: per-requester timeout error.
- `sram_cyc_o`  out  1: SRAM-side `cyc`.
- `sram_stb_o`  out  1: SRAM-side `stb`.
- `sram_we_o`  out  1: SRAM-side write enable.
- `sram_sel_o`  out  4: SRAM-side byte selects.
- `sram_adr_o`  out  32: SRAM-side address.
- `sram_dat_o`  out  32: SRAM-side write data.
- `sram_ack_i`  in  1: SRAM ack.
- `sram_dat_i`  in  32: SRAM read data.
- `grant_o`  out  NUM_REQ: one-hot grant, registered.
- `busy_o`  out  1: high whenever the state is not IDLE.

## Operation
- **States.**
  - IDLE: no owner.
  - OWN: granted requester drives the SRAM.
  - ERR: one cycle; error pulse to the owner.
  - DRAIN: wait for the owner to drop `cyc`.
- **IDLE → OWN.** Taken when any `req_cyc_i` bit is high.
  - Winner: first requester with `cyc` high, searching upward from `(last + 1) mod NUM_REQ`.
  - `last` is the most recently granted index; reset value `NUM_REQ-1`, so requester 0 has first priority after reset.
  - Registered on entry: `grant_o` = one-hot(winner), `last` ← winner, watchdog ← 0.
- **OWN, forwarding.** The owner's `cyc/stb/we/sel/adr/dat` pass combinationally to `sram_*`. `sram_cyc_o` = owner `cyc`; `sram_stb_o` = owner `stb`.
- **OWN, acks.** `sram_ack_i` is routed combinationally to the owner's `req_ack_o` bit only. `req_dat_o` = `sram_dat_i`.
- **OWN, bursts.** Multiple `stb` beats within one `cyc` are allowed; ownership persists until `cyc` drops.
- **OWN → IDLE.** When the owner's `cyc` is low, `grant_o` clears next edge. There is a minimum one-cycle IDLE gap between grants.
- **Watchdog.**
  - Increments each OWN cycle with owner `stb` high and `sram_ack_i` low.
  - Clears on ack or when `stb` is low.
  - Reaching TIMEOUT → ERR.
- **ERR.**
  - `sram_cyc_o` and `sram_stb_o` are forced 0.
  - Owner's `req_err_o` = 1 for exactly one cycle.
  - Then DRAIN; if the owner's `cyc` is already low, go to IDLE directly.
- **DRAIN.**
  - `sram_*` strobes stay 0 and `sram_ack_i` is ignored.
  - Go to IDLE when the owner's `cyc` goes low.
- **Default drive.** When not in OWN, all `sram_*` outputs, `req_ack_o`, and `req_dat_o` are 0.
- **Non-owners.** Never see ack or err, and their requests stay pending.
- **Boundary cases.**
  - Ack arriving on the same cycle the watchdog would expire: the ack wins and no error is raised.
  - Owner drops `cyc` on the same cycle as ack: the ack is delivered and the block releases.
  - Owner aborts (drops `cyc` before ack): SRAM-side `cyc` drops the same cycle. A late `sram_ack_i` arriving in IDLE is discarded.
  - Only one requester active: it is re-granted after each one-cycle IDLE gap.
  - Reset asserted mid-transfer: next edge puts the state in IDLE and all registered outputs at 0; `sram_cyc_o` is 0 in that cycle.

## Timing
- Reset values:
  - `grant_o` = 0, `busy_o` = 0, `last` = NUM_REQ-1, watchdog = 0.
  - All `sram_*` outputs and all `req_*_o` outputs = 0.
- Arbitration latency: requester `cyc` rises at edge N → `grant_o` and `sram_cyc_o` high after edge N+1.
- Data path: ack and read data are zero-latency passthrough while in OWN.
- Watchdog timing: error asserted TIMEOUT+1 cycles after `stb` with no ack.
- Worst-case wait for a requester: (NUM_REQ-1) × (longest other owner tenure + 1 gap cycle).

## Structure
- Package `wb_sched_pkg` contains:
  - the state enum (IDLE, OWN, ERR, DRAIN);
  - `WDOG_W` = 10;
  - function `onehot_to_idx`.
- Sub-module `rr_priority_picker`: combinational; inputs `req` [NUM_REQ] and `last`; outputs a one-hot winner and a `valid` flag.
- Top level holds the FSM, the grant register, the watchdog, and the muxes.

## Test plan
- **Single request.** Requester 2 reads address 0x10 and the SRAM acks 1 cycle after `stb`. Required: `grant_o` = 4'b0100 one edge after `cyc`, `req_ack_o[2]` pulses, `req_dat_o` = SRAM data, `busy_o` falls 1 cycle after `cyc` drops.
- **Rotation.** All four requesters hold `cyc` from reset with single-beat cycles. Required grant order 0,1,2,3,0, each separated by one IDLE cycle.
- **Timeout.** TIMEOUT=8 and the SRAM never acks requester 1. Required: `req_err_o[1]` pulses on the 9th stalled cycle, `sram_cyc_o` = 0 from then on, DRAIN holds until `cyc` drops, then requester 2 is granted.
- **Ack/timeout tie.** Ack arrives exactly on the expiry cycle. Required: ack delivered, no err.
- **Abort.** Owner drops `cyc` before ack and the SRAM acks one cycle later. Required: no ack reaches any requester and the next grant proceeds normally.
- **Mid-burst reset.** `wb_rst_i` asserted in the middle of a 4-beat burst. Required: all outputs 0 next edge; after reset, requester 0 is granted first.
